// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, state
// encodings and datapath mux/ALU selector codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; flags expiry on the last allowed
// wait cycle so the FSM can divert to HALT on the same edge.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && count_en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready
// stalls, wait timeout, cycle/instruction counters and halt on fault.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             BranchNot,
  output logic [3:0]       state,
  output logic             retire,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cyc_q, ins_q;

  logic       pc_write, pc_write_cond, branch_not;
  logic       iord, mem_read, mem_write, ir_write, memtoreg, regdst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       retire_c, fault_c;
  logic       tmr_en, tmr_expired;

  assign tmr_en = is_mem_wait(state_q) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != state_q),
    .count_en_i(tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_not    = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    retire_c      = 1'b0;
    fault_c       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmr_expired) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (tmr_expired) begin
          state_d = S_HALT;
        end
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (tmr_expired) begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        regdst    = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_not    = (op_q == OP_BNE);
        retire_c      = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        fault_c = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
      if (state_q != S_HALT) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if (retire_c) begin
        ins_q <= ins_q + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low combinationally during reset since FETCH itself drives requests.
  assign pc_en       = rst_n & (pc_write | (pc_write_cond & (zero ^ branch_not)));
  assign IorD        = rst_n & iord;
  assign MemRead     = rst_n & mem_read;
  assign MemWrite    = rst_n & mem_write;
  assign IRWrite     = rst_n & ir_write;
  assign MemtoReg    = rst_n & memtoreg;
  assign RegDst      = rst_n & regdst;
  assign RegWrite    = rst_n & reg_write;
  assign ALUSrcA     = rst_n & alu_src_a;
  assign ALUSrcB     = rst_n ? alu_src_b : '0;
  assign ALUOp       = rst_n ? alu_op : '0;
  assign PCSource    = rst_n ? pc_source : '0;
  assign BranchNot   = rst_n & branch_not;
  assign state       = rst_n ? state_q : '0;
  assign retire      = rst_n & retire_c;
  assign fault       = rst_n & fault_c;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule
